// File: rtl/comparator_3bit_seg.sv
// 3-bit magnitude comparator with a two-digit multiplexed 7-segment display.
// Define COMPARATOR_DP_EN to light the digit-0 decimal point whenever A equals B.
module comparator_3bit_seg #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       sel,
  output logic [2:0] O,
  output logic [7:0] seg_data,
  output logic [7:0] seg_com
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

  localparam logic [7:0] SegG     = 8'hBC;
  localparam logic [7:0] SegE     = 8'h9E;
  localparam logic [7:0] SegL     = 8'h1C;
  localparam logic [7:0] SegBlank = 8'h00;
  localparam logic [7:0] ComDig0  = 8'b1111_1110;
  localparam logic [7:0] ComDig1  = 8'b1111_1101;
  localparam logic [7:0] ComOff   = 8'hFF;

  typedef enum logic [2:0] {
    CmpNone = 3'b000,
    CmpLt   = 3'b001,
    CmpEq   = 3'b010,
    CmpGt   = 3'b100
  } cmp_e;

  logic [DivW-1:0] div_q, div_d;
  logic            digit_q, digit_d;
  cmp_e            cmp_q, cmp_d;
  logic [7:0]      seg_q, seg_d;
  logic [7:0]      com_q, com_d;
  logic [7:0]      seg_body;

  // Segment pattern {a..g, dp} for a decimal digit 0..7.
  function automatic logic [7:0] digit_seg(input logic [2:0] val);
    logic [7:0] code;
    unique case (val)
      3'd0: code = 8'hFC;
      3'd1: code = 8'h60;
      3'd2: code = 8'hDA;
      3'd3: code = 8'hF2;
      3'd4: code = 8'h66;
      3'd5: code = 8'hB6;
      3'd6: code = 8'hBE;
      3'd7: code = 8'hE0;
      default: code = SegBlank;
    endcase
    return code;
  endfunction

  always_comb begin
    div_d   = div_q + DivW'(1);
    digit_d = digit_q;
    if (div_q == DivLast) begin
      div_d   = '0;
      digit_d = ~digit_q;
    end
  end

  always_comb begin
    cmp_d = CmpEq;
    if (A > B) begin
      cmp_d = CmpGt;
    end else if (A < B) begin
      cmp_d = CmpLt;
    end
  end

  // Outputs are built from the current digit index so data and enable switch together.
  always_comb begin
    seg_body = SegBlank;
    if (!digit_q) begin
      if (sel) begin
        unique case (cmp_d)
          CmpGt:   seg_body = SegG;
          CmpLt:   seg_body = SegL;
          default: seg_body = SegE;
        endcase
      end else begin
        seg_body = digit_seg(B);
      end
    end else if (!sel) begin
      seg_body = digit_seg(A);
    end
    com_d = digit_q ? ComDig1 : ComDig0;
  end

  always_comb begin
    seg_d = seg_body;
`ifdef COMPARATOR_DP_EN
    seg_d[0] = !digit_q && (A == B);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= '0;
      digit_q <= 1'b0;
      cmp_q   <= CmpNone;
      seg_q   <= SegBlank;
      com_q   <= ComOff;
    end else begin
      div_q   <= div_d;
      digit_q <= digit_d;
      cmp_q   <= cmp_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
    end
  end

  assign O        = cmp_q;
  assign seg_data = seg_q;
  assign seg_com  = com_q;

endmodule

// File: tb/tb_comparator_3bit_seg.sv
// Randomized and directed bench for comparator_3bit_seg against a cycle-count scan model.
module tb_comparator_3bit_seg;

  localparam int unsigned ScanDiv = 16;
  localparam logic [7:0] DigTab [8] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] a = '0;
  logic [2:0] b = '0;
  logic       sel = 1'b0;
  logic [2:0] o;
  logic [7:0] seg_data;
  logic [7:0] seg_com;

  int n_checks = 0;
  int n_fail = 0;
  int k = 0;  // active edges since reset release

  comparator_3bit_seg #(.SCAN_DIV(ScanDiv)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .sel      (sel),
    .O        (o),
    .seg_data (seg_data),
    .seg_com  (seg_com)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model_o(input int av, input int bv);
    if (av > bv) return 3'b100;
    if (av == bv) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [7:0] model_seg(input int av, input int bv, input logic s, input int dig);
    logic [7:0] r;
    if (dig == 1) r = s ? 8'h00 : DigTab[av];
    else if (s) r = (av > bv) ? 8'hBC : (av == bv) ? 8'h9E : 8'h1C;
    else r = DigTab[bv];
`ifdef COMPARATOR_DP_EN
    if (dig == 0 && av == bv) r[0] = 1'b1;
`endif
    return r;
  endfunction

  // Apply inputs at negedge, then check the registered result just after the next posedge.
  task automatic step(input logic [2:0] av, input logic [2:0] bv, input logic s, input logic r);
    int dig;
    @(negedge clk);
    a = av; b = bv; sel = s; rst = r;
    @(posedge clk);
    #1;
    if (!r) begin
      check_eq("rst_o", 32'(o), 32'h0);
      check_eq("rst_seg", 32'(seg_data), 32'h00);
      check_eq("rst_com", 32'(seg_com), 32'hFF);
      k = 0;
    end else begin
      dig = (k / ScanDiv) % 2;
      check_eq("o", 32'(o), 32'(model_o(int'(av), int'(bv))));
      check_eq("seg", 32'(seg_data), 32'(model_seg(int'(av), int'(bv), s, dig)));
      check_eq("com", 32'(seg_com), (dig == 1) ? 32'hFD : 32'hFE);
      k++;
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] exp_d0;
    repeat (3) step(3'd5, 3'd2, 1'b0, 1'b0);

    // Operand display across both digits.
    step(3'd5, 3'd2, 1'b0, 1'b1);
    check_eq("d0_b_is_2", 32'(seg_data), 32'hDA);
    repeat (40) step(3'd5, 3'd2, 1'b0, 1'b1);
    repeat (20) step(3'd5, 3'd2, 1'b1, 1'b1);
    repeat (20) step(3'd3, 3'd3, 1'b0, 1'b1);
    repeat (20) step(3'd3, 3'd3, 1'b1, 1'b1);
    repeat (20) step(3'd1, 3'd6, 1'b1, 1'b1);
    repeat (40) step(3'd7, 3'd0, 1'b0, 1'b1);

    // Reset mid-scan while digit 1 is showing.
    for (int i = 0; i < 40 && !(((k / ScanDiv) % 2 == 1) && (k % ScanDiv == 5)); i++)
      step(3'd4, 3'd1, 1'b0, 1'b1);
    check_eq("on_digit1", 32'(seg_com), 32'hFD);
    step(3'd4, 3'd1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < ScanDiv; i++) begin
      step(3'd4, 3'd1, 1'b0, 1'b1);
      if (seg_com == 8'hFE) cnt++;
    end
    check_eq("dwell_after_rst", 32'(cnt), 32'(ScanDiv));
    step(3'd4, 3'd1, 1'b0, 1'b1);
    check_eq("switch_to_d1", 32'(seg_com), 32'hFD);

    // Random stimulus, inputs changing mid-scan.
    repeat (250) step(3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)), 1'b1);

    // Exhaustive sweep, re-aligned to digit 0 so every pair's digit-0 code is observed.
    step(3'd0, 3'd0, 1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      for (int av = 0; av < 8; av++) begin
        for (int bv = 0; bv < 8; bv++) begin
          if ((k / ScanDiv) % 2 == 1) step(3'(av), 3'(bv), 1'(s), 1'b0);
          step(3'(av), 3'(bv), 1'(s), 1'b1);
          exp_d0 = model_seg(av, bv, 1'(s), 0);
          check_eq("sweep_d0", 32'(seg_data), 32'(exp_d0));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_3bit_seg.md
COMPARATOR_3BIT_SEG -- requirements
Module: comparator_3bit_seg

Interface
REQ-001 Parameter SCAN_DIV, default 16, meaning: clock cycles each display digit stays active (legal range 2..65535).
REQ-002 Port clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  reset; it SHALL be synchronous and active-low.
REQ-004 Port A  input  3  unsigned operand A.
REQ-005 Port B  input  3  unsigned operand B.
REQ-006 Port sel  input  1  display mode: 0 = show operands, 1 = show comparison result.
REQ-007 Port O  output  3  registered one-hot compare result {gt, eq, lt}.
REQ-008 Port seg_data  output  8  registered segment drive {a,b,c,d,e,f,g,dp}, bit7 = a, active-high.
REQ-009 Port seg_com  output  8  registered digit enables, active-low; bit0 = rightmost digit.

Function
REQ-010 O SHALL be 3'b100 when A>B, 3'b010 when A==B, 3'b001 when A<B; exactly one bit set outside reset.
REQ-011 O SHALL reflect A/B sampled at a rising edge, visible after that edge (1-cycle latency).
REQ-012 A free-running divider SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index SHALL toggle between 0 and 1.
REQ-013 seg_com SHALL be 8'b11111110 for digit index 0 and 8'b11111101 for index 1; digits 2..7 SHALL stay off (1).
REQ-014 sel=0: digit 1 SHALL show A, digit 0 SHALL show B, as decimal 0..7.
REQ-015 sel=1: digit 1 SHALL be blank (8'h00); digit 0 SHALL show 'G' if A>B, 'E' if equal, 'L' if A<B.
REQ-016 Digit codes (dp=0): 0=FC,1=60,2=DA,3=F2,4=66,5=B6,6=BE,7=E0,G=BC,E=9E,L=1C, blank=00.
REQ-017 seg_data and seg_com SHALL be registered together from the same edge's digit index, A, B, sel (1-cycle latency, no glitch between them).
REQ-018 Changes of A, B or sel mid-scan SHALL take effect on the next edge without resetting the divider or digit index.
REQ-019 Purely combinational paths from inputs to outputs SHALL NOT exist.

Reset
REQ-020 While rst=0 at a rising edge: O=3'b000, seg_data=8'h00, seg_com=8'hFF, divider=0, digit index=0.
REQ-021 Reset asserted mid-scan SHALL take priority over all other updates at that edge.
REQ-022 On the first edge with rst=1, outputs SHALL drive digit 0 per REQ-014/015 and O per REQ-010.

Configuration
REQ-023 Macro COMPARATOR_DP_EN: when defined, the dp bit (seg_data[0]) SHALL be 1 on digit 0 whenever A==B, in both sel modes.
REQ-024 Without COMPARATOR_DP_EN, seg_data[0] SHALL be constant 0 and no dp logic SHALL be synthesized.

Verification
REQ-025 Reset held 3 cycles, then A=5,B=2,sel=0 -> O=100; digit0 seg_data=DA (2), digit1 seg_data=B6 (5), seg_com alternating FE/FD every 16 cycles.
REQ-026 A=5,B=2,sel=1 -> O=100; digit0 seg_data=BC ('G'), digit1 seg_data=00.
REQ-027 A=3,B=3,sel=0 then sel=1 -> O=010; digit0 F2 then 9E ('E'); with COMPARATOR_DP_EN digit0 F3 then 9F.
REQ-028 A=1,B=6,sel=1 -> O=001, digit0 seg_data=1C ('L'); A=7,B=0,sel=0 -> O=100, digit1 E0, digit0 FC.
REQ-029 rst driven low mid-scan on digit 1 -> next edge O=000, seg_data=00, seg_com=FF; after release scan restarts at digit 0 with a full SCAN_DIV dwell.
REQ-030 Exhaustive sweep of all 64 A/B pairs, both sel values -> O and digit-0 code match REQ-010/015/016 one cycle after each change.
